store_req_ctrl: RTL and testbench
=================================

Name: store_req_ctrl

Overview:
- Memory-stage store-side unit of the CPU datapath. It is the write-direction counterpart of the load-data extraction logic.
- Converts SB/SH/SW in M stage into a byte-lane-replicated write transaction with byte strobes on the data-side SRAM-like bus.
- Detects store address errors (AdES).
- Holds the pipeline with a stall until the bus transaction completes.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data bus data width (fixed 32; strobe width DATA_W/8)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- memwriteM  in  1  M-stage instruction is a store
- alucontrolM  in  8  M-stage op code (`EXE_SB_OP / `EXE_SH_OP / `EXE_SW_OP from defines.vh)
- aluoutM  in  32  effective address
- writedataM  in  32  rt store data
- flushM  in  1  exception/eret flush of M stage
- advanceM  in  1  M→W pipeline register loads this cycle
- adesM  out  1  store address error (combinational)
- bad_addrM  out  32  faulting address (= aluoutM when adesM, else 0)
- stallM  out  1  hold pipeline
- data_req  out  1  bus request
- data_wr  out  1  write indicator (1 whenever data_req)
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  32  request address
- data_wstrb  out  4  byte strobes
- data_wdata  out  32  replicated write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  write completed

Behaviour:

Combinational decode of `start = memwriteM & op in {SB,SH,SW}`:
- SB: always legal. size=0. wstrb = 4'b0001 << aluoutM[1:0]. wdata = {4{writedataM[7:0]}}.
- SH: adesM=1 if aluoutM[0]=1. size=1. wstrb = 0011 for addr[1]=0, 1100 for addr[1]=1. wdata = {2{writedataM[15:0]}}.
- SW: adesM=1 if aluoutM[1:0]≠0. size=2. wstrb=1111. wdata=writedataM.
- memwriteM with any other op code: nop. adesM=0, no request.
- adesM is qualified by memwriteM only. It is not masked by flushM; the exception unit prioritises.

FSM states: IDLE, REQ, WAIT, DONE.
- IDLE → REQ when start & ~adesM & ~flushM. addr/size/wstrb/wdata are registered on this edge. stallM=1 combinationally in this cycle.
- REQ: data_req=1, data_wr=1, and bus outputs are held stable.
  - data_addr_ok & data_data_ok → DONE.
  - data_addr_ok only → WAIT.
  - flushM & ~data_addr_ok → IDLE; the request is dropped with no bus effect.
- WAIT: data_req=0. data_data_ok → DONE. flushM is ignored: an accepted write always completes.
- DONE: stallM=0.
  - advanceM → IDLE.
  - Otherwise stay in DONE; the same store is never reissued.
  - flushM → IDLE.
- stallM = (IDLE & start & ~adesM & ~flushM) | REQ | WAIT.

Latency:
- data_req rises at T+1 after a start in cycle T.
- Best case: addr_ok at T+1 and data_ok at T+1 gives DONE at T+2 and stallM=0 at T+2.

Reset (synchronous):
- state=IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0, stallM=0.
- Reset mid-transaction abandons the transaction; the bus side is reset concurrently.
- bad_addrM and adesM are combinational: 0 when memwriteM=0.

Test Plan:
- SB addr 0x80000003, wd 0x123456AB, addr_ok T+1, data_ok T+2 → wstrb=1000, wdata=0xABABABAB, size=0, stallM high at T..T+2, low at T+3.
- SH addr 0x80000002, wd 0xDEADBEEF, addr_ok and data_ok same cycle → wstrb=1100, wdata=0xBEEFBEEF, size=1, DONE at T+2.
- SW addr 0x80000006 → adesM=1, bad_addrM=0x80000006, data_req never asserts, stallM=0. SH addr 0x80000001 → adesM=1.
- SW addr 0x80000010; flushM in first REQ cycle with addr_ok=0 → data_req drops next cycle, state IDLE. Flush in WAIT → FSM waits for data_ok, then DONE.
- SW completes with advanceM=0 for 3 cycles in DONE → exactly one data_req handshake observed; IDLE after advanceM=1.
- rst asserted in WAIT → next cycle all outputs 0 and state IDLE; a following SB issues normally.

Source files
------------

// File: rtl/store_req_ctrl.sv
// Store-side M-stage unit: turns SB/SH/SW into a byte-strobed, lane-replicated
// write on the data SRAM-like bus, flags AdES and stalls until the write lands.
module store_req_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [7:0]  EXE_SB_OP = 8'b1110_1000,
  parameter logic [7:0]  EXE_SH_OP = 8'b1110_1001,
  parameter logic [7:0]  EXE_SW_OP = 8'b1110_1011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memwriteM,
  input  logic [7:0]            alucontrolM,
  input  logic [ADDR_W-1:0]     aluoutM,
  input  logic [DATA_W-1:0]     writedataM,
  input  logic                  flushM,
  input  logic                  advanceM,
  output logic                  adesM,
  output logic [ADDR_W-1:0]     bad_addrM,
  output logic                  stallM,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic is_sb, is_sh, is_sw, start, issue;

  assign is_sb = (alucontrolM == EXE_SB_OP);
  assign is_sh = (alucontrolM == EXE_SH_OP);
  assign is_sw = (alucontrolM == EXE_SW_OP);
  assign start = memwriteM & (is_sb | is_sh | is_sw);

  // AdES is not masked by flushM; the exception unit arbitrates priority.
  assign adesM     = memwriteM & ((is_sh & aluoutM[0]) | (is_sw & (aluoutM[1:0] != 2'b00)));
  assign bad_addrM = adesM ? aluoutM : '0;

  assign issue = (state_q == ST_IDLE) & start & ~adesM & ~flushM;

  always_comb begin
    addr_d  = aluoutM;
    size_d  = 2'd0;
    wstrb_d = '0;
    wdata_d = writedataM;
    if (is_sb) begin
      size_d  = 2'd0;
      wstrb_d = 4'b0001 << aluoutM[1:0];
      wdata_d = {4{writedataM[7:0]}};
    end else if (is_sh) begin
      size_d  = 2'd1;
      wstrb_d = aluoutM[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{writedataM[15:0]}};
    end else if (is_sw) begin
      size_d  = 2'd2;
      wstrb_d = 4'b1111;
      wdata_d = writedataM;
    end
  end

  always_comb begin
    state_d  = state_q;
    stallM   = 1'b0;
    data_req = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_REQ;
          stallM  = 1'b1;
        end
      end
      ST_REQ: begin
        data_req = 1'b1;
        stallM   = 1'b1;
        if (data_addr_ok) begin
          state_d = data_data_ok ? ST_DONE : ST_WAIT;
        end else if (flushM) begin
          state_d = ST_IDLE;
        end
      end
      // An accepted write always completes, so flushM is not looked at here.
      ST_WAIT: begin
        stallM = 1'b1;
        if (data_data_ok) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (advanceM | flushM) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        wstrb_q <= wstrb_d;
        wdata_q <= wdata_d;
      end
    end
  end

  assign data_wr    = data_req;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_store_req_ctrl.sv
// Bench for store_req_ctrl: directed scenarios plus randomized stores checked
// against a transaction-level model of strobes, replication and stall timing.
module tb_store_req_ctrl;

  localparam logic [7:0] OP_SB = 8'b1110_1000;
  localparam logic [7:0] OP_SH = 8'b1110_1001;
  localparam logic [7:0] OP_SW = 8'b1110_1011;
  localparam logic [7:0] OP_XX = 8'b1110_0011;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwriteM;
  logic [7:0]  alucontrolM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        flushM;
  logic        advanceM;
  logic        adesM;
  logic [31:0] bad_addrM;
  logic        stallM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  int checks = 0;
  int errors = 0;

  store_req_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .memwriteM    (memwriteM),
    .alucontrolM  (alucontrolM),
    .aluoutM      (aluoutM),
    .writedataM   (writedataM),
    .flushM       (flushM),
    .advanceM     (advanceM),
    .adesM        (adesM),
    .bad_addrM    (bad_addrM),
    .stallM       (stallM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok)
  );

  always #5 clk = ~clk;

  // Reference model: access width in bytes, 0 for a non-store op.
  function automatic int width_of(input logic [7:0] op);
    if (op == OP_SB) return 1;
    if (op == OP_SH) return 2;
    if (op == OP_SW) return 4;
    return 0;
  endfunction

  function automatic logic m_ades(input logic mw, input logic [7:0] op, input logic [31:0] a);
    int w = width_of(op);
    return mw && (w > 1) && ((a % w) != 0);
  endfunction

  function automatic logic [3:0] m_strb(input logic [7:0] op, input logic [31:0] a);
    int w    = width_of(op);
    int lane = int'(a % 4) - int'(a % 4) % w;
    int m    = ((1 << w) - 1) << lane;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] wd);
    int w = width_of(op);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % w) +: 8];
    return r;
  endfunction

  function automatic logic [1:0] m_size(input logic [7:0] op);
    int w = width_of(op);
    return (w == 1) ? 2'd0 : (w == 2) ? 2'd1 : 2'd2;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    memwriteM = 0; alucontrolM = 8'h00; aluoutM = 0; writedataM = 0;
    flushM = 0; advanceM = 0; data_addr_ok = 0; data_data_ok = 0;
  endtask

  task automatic present(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd);
    memwriteM = 1; alucontrolM = op; aluoutM = a; writedataM = wd;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    checks++;
    if ({stallM, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, adesM, bad_addrM} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b wr=%b size=%0d addr=%h strb=%b wdata=%h ades=%b bad=%h, required all 0",
               stallM, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, adesM, bad_addrM);
    end
  endtask

  task automatic test_sb_split();
    tick(); present(OP_SB, 32'h8000_0003, 32'h1234_56AB); #1;
    checks++;
    if ({stallM, data_req, adesM} !== 3'b100) begin
      errors++; $display("FAIL sb_T: stall/req/ades=%b required 100", {stallM, data_req, adesM});
    end
    tick(); data_addr_ok = 1; #1;
    checks++;
    if ({stallM, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata} !==
        {3'b111, 2'd0, 32'h8000_0003, 4'b1000, 32'hABAB_ABAB}) begin
      errors++;
      $display("FAIL sb_req: stall=%b req=%b wr=%b size=%0d addr=%h strb=%b wdata=%h, required 1 1 1 0 80000003 1000 abababab",
               stallM, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata);
    end
    tick(); data_addr_ok = 0; data_data_ok = 1; #1;
    checks++;
    if ({stallM, data_req} !== 2'b10) begin
      errors++; $display("FAIL sb_wait: stall/req=%b required 10", {stallM, data_req});
    end
    tick(); data_data_ok = 0; advanceM = 1; #1;
    checks++;
    if ({stallM, data_req} !== 2'b00) begin
      errors++; $display("FAIL sb_done: stall/req=%b required 00", {stallM, data_req});
    end
    tick(); drive_idle();
  endtask

  task automatic test_sh_same_cycle();
    tick(); present(OP_SH, 32'h8000_0002, 32'hDEAD_BEEF); #1;
    checks++;
    if (stallM !== 1'b1) begin errors++; $display("FAIL sh_T: stall=%b required 1", stallM); end
    tick(); data_addr_ok = 1; data_data_ok = 1; #1;
    checks++;
    if ({data_req, data_size, data_wstrb, data_wdata} !== {1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF}) begin
      errors++;
      $display("FAIL sh_req: req=%b size=%0d strb=%b wdata=%h, required 1 1 1100 beefbeef",
               data_req, data_size, data_wstrb, data_wdata);
    end
    tick(); data_addr_ok = 0; data_data_ok = 0; advanceM = 1; #1;
    checks++;
    if ({stallM, data_req} !== 2'b00) begin
      errors++; $display("FAIL sh_done_T2: stall/req=%b required 00", {stallM, data_req});
    end
    tick(); drive_idle();
  endtask

  task automatic test_ades();
    tick(); present(OP_SW, 32'h8000_0006, 32'h1111_2222); flushM = 1; #1;
    checks++;
    if ({adesM, bad_addrM, stallM} !== {1'b1, 32'h8000_0006, 1'b0}) begin
      errors++; $display("FAIL sw_ades: ades=%b bad=%h stall=%b required 1 80000006 0", adesM, bad_addrM, stallM);
    end
    flushM = 0; #1;
    checks++;
    if ({adesM, stallM} !== 2'b10) begin
      errors++; $display("FAIL sw_ades_noflush: ades/stall=%b required 10", {adesM, stallM});
    end
    tick(); present(OP_SH, 32'h8000_0001, 32'h0); #1;
    checks++;
    if ({adesM, bad_addrM, data_req, stallM} !== {1'b1, 32'h8000_0001, 2'b00}) begin
      errors++; $display("FAIL sh_ades: ades=%b bad=%h req=%b stall=%b required 1 80000001 0 0", adesM, bad_addrM, data_req, stallM);
    end
    tick(); memwriteM = 0; #1;
    checks++;
    if ({adesM, bad_addrM, data_req} !== '0) begin
      errors++; $display("FAIL ades_nomw: ades=%b bad=%h req=%b required 0 0 0", adesM, bad_addrM, data_req);
    end
    tick(); present(OP_XX, 32'h8000_0003, 32'h0); #1;
    checks++;
    if ({adesM, stallM} !== 2'b00) begin
      errors++; $display("FAIL other_op: ades/stall=%b required 00", {adesM, stallM});
    end
    tick(); #1;
    checks++;
    if (data_req !== 1'b0) begin errors++; $display("FAIL other_op_req: req=%b required 0", data_req); end
    drive_idle();
  endtask

  task automatic test_flush();
    tick(); present(OP_SW, 32'h8000_0010, 32'hCAFE_F00D);
    tick(); flushM = 1; #1;
    checks++;
    if (data_req !== 1'b1) begin errors++; $display("FAIL flush_req_seen: req=%b required 1", data_req); end
    tick(); drive_idle(); #1;
    checks++;
    if ({stallM, data_req} !== 2'b00) begin
      errors++; $display("FAIL flush_req_drop: stall/req=%b required 00", {stallM, data_req});
    end
    present(OP_SW, 32'h8000_0010, 32'hCAFE_F00D); #1;
    checks++;
    if (stallM !== 1'b1) begin errors++; $display("FAIL flush_idle_probe: stall=%b required 1", stallM); end
    tick(); data_addr_ok = 1;
    tick(); data_addr_ok = 0; flushM = 1; memwriteM = 0; #1;
    checks++;
    if ({stallM, data_req} !== 2'b10) begin
      errors++; $display("FAIL flush_wait: stall/req=%b required 10", {stallM, data_req});
    end
    tick(); flushM = 0; #1;
    checks++;
    if (stallM !== 1'b1) begin errors++; $display("FAIL flush_wait_hold: stall=%b required 1", stallM); end
    tick(); data_data_ok = 1;
    tick(); data_data_ok = 0; #1;
    checks++;
    if ({stallM, data_req} !== 2'b00) begin
      errors++; $display("FAIL flush_wait_done: stall/req=%b required 00", {stallM, data_req});
    end
    flushM = 1;
    tick(); flushM = 0; present(OP_SB, 32'h0, 32'h0); #1;
    checks++;
    if (stallM !== 1'b1) begin errors++; $display("FAIL done_flush_idle: stall=%b required 1", stallM); end
    tick(); flushM = 1;
    tick(); drive_idle();
  endtask

  task automatic test_hold_done();
    int reqs = 0;
    tick(); present(OP_SW, 32'h8000_0020, 32'h0BAD_CAFE); #1;
    if (data_req) reqs++;
    tick(); data_addr_ok = 1; data_data_ok = 1; #1;
    if (data_req) reqs++;
    tick(); data_addr_ok = 0; data_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (data_req) reqs++;
      checks++;
      if (stallM !== 1'b0) begin errors++; $display("FAIL hold_done_stall%0d: stall=%b required 0", i, stallM); end
      tick();
    end
    checks++;
    if (reqs != 1) begin errors++; $display("FAIL hold_done_reqs: req cycles=%0d required 1", reqs); end
    advanceM = 1;
    tick(); advanceM = 0; present(OP_SB, 32'h8000_0021, 32'h77); #1;
    checks++;
    if (stallM !== 1'b1) begin errors++; $display("FAIL hold_done_idle: stall=%b required 1", stallM); end
    tick(); flushM = 1;
    tick(); drive_idle();
  endtask

  task automatic test_rst_in_wait();
    tick(); present(OP_SW, 32'h8000_0040, 32'h5555_AAAA);
    tick(); data_addr_ok = 1;
    tick(); data_addr_ok = 0; memwriteM = 0; rst = 1;
    tick(); rst = 0; #1;
    checks++;
    if ({stallM, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_wait: stall=%b req=%b size=%0d addr=%h strb=%b wdata=%h required all 0",
               stallM, data_req, data_size, data_addr, data_wstrb, data_wdata);
    end
    tick(); present(OP_SB, 32'h8000_0041, 32'h0000_00C3); #1;
    checks++;
    if (stallM !== 1'b1) begin errors++; $display("FAIL rst_sb_start: stall=%b required 1", stallM); end
    tick(); data_addr_ok = 1; data_data_ok = 1; #1;
    checks++;
    if ({data_req, data_wstrb, data_wdata} !== {1'b1, 4'b0010, 32'hC3C3_C3C3}) begin
      errors++; $display("FAIL rst_sb_req: req=%b strb=%b wdata=%h required 1 0010 c3c3c3c3", data_req, data_wstrb, data_wdata);
    end
    tick(); data_addr_ok = 0; data_data_ok = 0; advanceM = 1;
    tick(); drive_idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      logic [7:0]  op;
      logic [31:0] a, wd;
      int alat, dlat, hold, sel;
      logic legal, e_ades;
      sel  = $urandom_range(0, 3);
      op   = (sel == 0) ? OP_SB : (sel == 1) ? OP_SH : (sel == 2) ? OP_SW : OP_XX;
      a    = $urandom; wd = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      alat = $urandom_range(0, 3); dlat = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      e_ades = m_ades(1'b1, op, a);
      legal  = (width_of(op) > 0) && !e_ades;
      tick(); present(op, a, wd); advanceM = 0; #1;
      checks++;
      if ({adesM, bad_addrM, stallM} !== {e_ades, (e_ades ? a : 32'h0), legal}) begin
        errors++;
        $display("FAIL rnd%0d_start: ades=%b bad=%h stall=%b required %b %h %b", n, adesM, bad_addrM, stallM,
                 e_ades, (e_ades ? a : 32'h0), legal);
      end
      if (legal) begin
        for (int k = 0; k <= alat; k++) begin
          tick();
          data_addr_ok = (k == alat);
          data_data_ok = (k == alat) && (dlat == 0);
          #1;
          checks++;
          if ({stallM, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata} !==
              {3'b111, m_size(op), a, m_strb(op, a), m_wdata(op, wd)}) begin
            errors++;
            $display("FAIL rnd%0d_req: stall=%b req=%b wr=%b size=%0d addr=%h strb=%b wdata=%h required 1 1 1 %0d %h %b %h",
                     n, stallM, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
                     m_size(op), a, m_strb(op, a), m_wdata(op, wd));
          end
        end
        for (int k = 0; k < dlat; k++) begin
          tick(); data_addr_ok = 0; data_data_ok = (k == dlat - 1); #1;
          checks++;
          if ({stallM, data_req} !== 2'b10) begin
            errors++; $display("FAIL rnd%0d_wait: stall/req=%b required 10", n, {stallM, data_req});
          end
        end
        for (int k = 0; k <= hold; k++) begin
          tick(); data_addr_ok = 0; data_data_ok = 0; advanceM = (k == hold); #1;
          checks++;
          if ({stallM, data_req} !== 2'b00) begin
            errors++; $display("FAIL rnd%0d_done: stall/req=%b required 00", n, {stallM, data_req});
          end
        end
      end
      tick(); drive_idle(); #1;
      checks++;
      if ({stallM, data_req} !== 2'b00) begin
        errors++; $display("FAIL rnd%0d_idle: stall/req=%b required 00", n, {stallM, data_req});
      end
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_sb_split();
    test_sh_same_cycle();
    test_ades();
    test_flush();
    test_hold_done();
    test_rst_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
